// File: rtl/input_port_buffer_pkg.sv
// Shared flit framing codes and framing-FSM states for the router input port buffer.
package input_port_buffer_pkg;

  localparam int unsigned IPB_DATA_WIDTH = 32;
  localparam int unsigned FLIT_TYPE_W    = 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_INVALID = 2'b00,
    FLIT_HEAD    = 2'b01,
    FLIT_BODY    = 2'b10,
    FLIT_TAIL    = 2'b11
  } flit_type_e;

  typedef enum logic {
    IPB_IDLE = 1'b0,
    IPB_PKT  = 1'b1
  } ipb_state_e;

endpackage

// File: rtl/input_port_buffer_fifo_mem.sv
// Flit storage: DEPTH x DATA_WIDTH array, synchronous write, asynchronous read.
module input_port_buffer_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AW         = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/input_port_buffer.sv
// Router input port: FWFT flit FIFO with upstream credit return, framing tracker and
// sticky overflow/protocol error flags.
module input_port_buffer
  import input_port_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = IPB_DATA_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  datain,
  input  logic                   validin,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  dataout,
  output logic [FLIT_TYPE_W-1:0] flit_type,
  output logic                   empty,
  output logic                   full,
  output logic [CNT_W-1:0]       count,
  output logic                   credit_out,
  output logic                   pkt_active,
  output logic                   err_overflow,
  output logic                   err_protocol
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  push;
  logic                  pop;
  flit_type_e            pop_type;
  ipb_state_e            state;

  input_port_buffer_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (datain),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  // A full buffer still accepts a flit when a pop frees a slot in the same cycle.
  assign push  = validin && (!full || pop);
  assign pop   = rd_en && !empty;

  // Gating on empty hides stale memory and forces zero as soon as reset clears count.
  assign dataout   = empty ? '0 : rd_data;
  assign flit_type = dataout[DATA_WIDTH-1 -: FLIT_TYPE_W];
  assign pop_type  = flit_type_e'(rd_data[DATA_WIDTH-1 -: FLIT_TYPE_W]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      credit_out   <= 1'b0;
      state        <= IPB_IDLE;
      pkt_active   <= 1'b0;
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      credit_out <= pop;

      if (validin && full && !pop) err_overflow <= 1'b1;

      if (pop) begin
        case (state)
          IPB_IDLE: begin
            if (pop_type == FLIT_HEAD) begin
              state      <= IPB_PKT;
              pkt_active <= 1'b1;
            end else begin
              err_protocol <= 1'b1;
            end
          end
          IPB_PKT: begin
            case (pop_type)
              FLIT_BODY: ;
              FLIT_TAIL: begin
                state      <= IPB_IDLE;
                pkt_active <= 1'b0;
              end
              default: err_protocol <= 1'b1;
            endcase
          end
          default: begin
            state      <= IPB_IDLE;
            pkt_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed self-checking bench for input_port_buffer (DATA_WIDTH=32, DEPTH=4).
module tb_input_port_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] datain;
  logic        validin;
  logic        rd_en;
  logic [31:0] dataout;
  logic [1:0]  flit_type;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        credit_out;
  logic        pkt_active;
  logic        err_overflow;
  logic        err_protocol;

  int compared   = 0;
  int mismatched = 0;

  input_port_buffer #(
    .DATA_WIDTH (32),
    .DEPTH      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .datain       (datain),
    .validin      (validin),
    .rd_en        (rd_en),
    .dataout      (dataout),
    .flit_type    (flit_type),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .credit_out   (credit_out),
    .pkt_active   (pkt_active),
    .err_overflow (err_overflow),
    .err_protocol (err_protocol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clock, then settle 1 time unit past the edge.
  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    validin = v;
    datain  = d;
    rd_en   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    validin = 1'b0;
    rd_en   = 1'b0;
    datain  = '0;
    rst     = 1'b0;
    #12;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; validin = 1'b0; rd_en = 1'b0; datain = '0;
    #3;
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dataout", dataout, 32'd0);

    // Packet head/body/tail
    cyc(1, 32'h4000_00AA, 0);
    chk("pkt_push_vis", dataout, 32'h4000_00AA);
    chk("pkt_ftype_head", 32'(flit_type), 32'd1);
    cyc(1, 32'h8000_0001, 0);
    cyc(1, 32'hC000_0002, 0);
    chk("pkt_count3", 32'(count), 32'd3);
    cyc(0, 0, 1);
    chk("pkt_pop1_data", dataout, 32'h8000_0001);
    chk("pkt_pop1_credit", 32'(credit_out), 32'd1);
    chk("pkt_pop1_active", 32'(pkt_active), 32'd1);
    cyc(0, 0, 1);
    chk("pkt_pop2_data", dataout, 32'hC000_0002);
    chk("pkt_pop2_credit", 32'(credit_out), 32'd1);
    chk("pkt_pop2_active", 32'(pkt_active), 32'd1);
    cyc(0, 0, 1);
    chk("pkt_pop3_empty", 32'(empty), 32'd1);
    chk("pkt_pop3_data0", dataout, 32'd0);
    chk("pkt_pop3_credit", 32'(credit_out), 32'd1);
    chk("pkt_pop3_active", 32'(pkt_active), 32'd0);
    cyc(0, 0, 0);
    chk("pkt_credit_end", 32'(credit_out), 32'd0);
    chk("pkt_errs", {30'd0, err_overflow, err_protocol}, 32'd0);

    // Full / overflow / push+pop while full
    cyc(1, 32'h4000_0010, 0);
    cyc(1, 32'h8000_0011, 0);
    cyc(1, 32'h8000_0012, 0);
    cyc(1, 32'h8000_0013, 0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_flag", 32'(full), 32'd1);
    cyc(1, 32'h8000_0014, 0);
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_front", dataout, 32'h4000_0010);
    cyc(1, 32'hC000_0015, 1);
    chk("fullpp_count", 32'(count), 32'd4);
    chk("fullpp_credit", 32'(credit_out), 32'd1);
    chk("fullpp_front", dataout, 32'h8000_0011);
    chk("fullpp_active", 32'(pkt_active), 32'd1);
    cyc(0, 0, 1);
    chk("drain1", dataout, 32'h8000_0012);
    cyc(0, 0, 1);
    chk("drain2", dataout, 32'h8000_0013);
    cyc(0, 0, 1);
    chk("drain3_no_dropped", dataout, 32'hC000_0015);
    chk("drain3_ftype_tail", 32'(flit_type), 32'd3);
    cyc(0, 0, 1);
    chk("drain4_empty", 32'(empty), 32'd1);
    chk("drain4_active", 32'(pkt_active), 32'd0);
    chk("drain_no_proto", 32'(err_protocol), 32'd0);

    // Asynchronous reset mid-traffic, asserted away from any clock edge
    cyc(1, 32'h4000_0020, 0);
    cyc(1, 32'h8000_0021, 1);
    chk("pre_rst_credit", 32'(credit_out), 32'd1);
    chk("pre_rst_active", 32'(pkt_active), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_count", 32'(count), 32'd0);
    chk("async_credit", 32'(credit_out), 32'd0);
    chk("async_dataout", dataout, 32'd0);
    chk("async_active", 32'(pkt_active), 32'd0);
    chk("async_errs", {30'd0, err_overflow, err_protocol}, 32'd0);
    validin = 1'b0; rd_en = 1'b0;
    #6;
    rst = 1'b1;
    @(posedge clk); #1;
    cyc(0, 0, 0);
    chk("post_rst_credit", 32'(credit_out), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);

    // Pointer wrap with streaming push/pop
    cyc(1, 32'd0, 0);
    chk("wrap_first", dataout, 32'd0);
    for (int i = 1; i < 10; i++) begin
      cyc(1, 32'(i), 1);
      chk($sformatf("wrap_data%0d", i), dataout, 32'(i));
      chk($sformatf("wrap_count%0d", i), 32'(count), 32'd1);
    end
    cyc(0, 0, 1);
    chk("wrap_final_empty", 32'(empty), 32'd1);
    chk("wrap_no_ovf", 32'(err_overflow), 32'd0);

    // Protocol errors
    do_reset();
    cyc(1, 32'h8000_0000, 0);
    cyc(0, 0, 1);
    chk("proto_body_idle", 32'(err_protocol), 32'd1);
    chk("proto_body_idle_act", 32'(pkt_active), 32'd0);
    cyc(1, 32'h4000_0001, 0);
    cyc(1, 32'h4000_0002, 0);
    cyc(0, 0, 1);
    chk("proto_head1_act", 32'(pkt_active), 32'd1);
    cyc(0, 0, 1);
    chk("proto_head2_act", 32'(pkt_active), 32'd1);
    chk("proto_sticky", 32'(err_protocol), 32'd1);

    // Empty reads leave everything alone (still in PKT)
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1);
      chk($sformatf("emptyrd_count%0d", i), 32'(count), 32'd0);
      chk($sformatf("emptyrd_credit%0d", i), 32'(credit_out), 32'd0);
      chk($sformatf("emptyrd_active%0d", i), 32'(pkt_active), 32'd1);
    end
    cyc(1, 32'hC000_0003, 0);
    cyc(0, 0, 1);
    chk("tail_closes", 32'(pkt_active), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
